// File: rtl/register_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants for the multi-port register file. Holds the
//               default data width, register count and read-port count, the
//               fixed write-port count, and the address-width helper.
// Macros      : REGFILE_BYPASS_EN (used by the register file and scoreboard)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NREAD = 2;
    localparam int NWRITE    = 2;

    // Address width for a register count (NREGS is a power of two, >= 2).
    function automatic int aw_of(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp_if
// Description : Bus bundle of the multi-port register file.
//   rd_select  NREAD*AW    packed read addresses, port k at [k*AW +: AW]
//   rd_data    NREAD*XLEN  packed combinational read data
//   rd_busy    NREAD       busy flag of each port's selected register
//   wr_en      2           write enables, ports 0 and 1
//   wr_select  2*AW        packed write addresses
//   wr_data    2*XLEN      packed write data
//   rsv_en     1           reserve a destination register
//   rsv_select AW          register to reserve
//   conflict   1           registered dual-write collision pulse
//   master modport drives requests, slave modport is the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NREAD = DEF_NREAD
);
    localparam int AW = aw_of(NREGS);

    logic [NREAD*AW-1:0]    rd_select;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_select;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   rsv_en;
    logic [AW-1:0]          rsv_select;
    logic                   conflict;

    modport master (
        output rd_select, wr_en, wr_select, wr_data, rsv_en, rsv_select,
        input  rd_data, rd_busy, conflict
    );

    modport slave (
        input  rd_select, wr_en, wr_select, wr_data, rsv_en, rsv_select,
        output rd_data, rd_busy, conflict
    );

endinterface
`default_nettype wire

// File: rtl/register_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : register_file_scoreboard
// Description : One busy bit per register. A reservation sets the bit, any
//               enabled write clears it, and a same-cycle reservation beats
//               the clear. Register 0 is never busy.
//   clock, reset_n          clock and synchronous active-low reset
//   rsv_en, rsv_select      reservation request
//   wr_en, wr_select        the two write ports (clear sources)
//   rd_select               packed read addresses
//   busy                    full busy vector (stored state)
//   rd_busy                 busy flag per read port
// Macros      : REGFILE_BYPASS_EN - a register written this cycle reports
//               the post-edge busy value (set only if reserved this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NREAD = DEF_NREAD,
    parameter int AW    = aw_of(NREGS)
) (
    input  wire logic                  clock,
    input  wire logic                  reset_n,
    input  wire logic                  rsv_en,
    input  wire logic [AW-1:0]         rsv_select,
    input  wire logic [NWRITE-1:0]     wr_en,
    input  wire logic [NWRITE*AW-1:0]  wr_select,
    input  wire logic [NREAD*AW-1:0]   rd_select,
    output logic      [NREGS-1:0]      busy,
    output logic      [NREAD-1:0]      rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;
    logic [AW-1:0]    w_ws0;
    logic [AW-1:0]    w_ws1;

    assign w_ws0 = wr_select[0  +: AW];
    assign w_ws1 = wr_select[AW +: AW];

    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if ((wr_en[0] && w_ws0 == AW'(i)) || (wr_en[1] && w_ws1 == AW'(i)))
                w_busy_next[i] = 1'b0;
            // Reservation is applied last so it wins over a same-cycle write.
            if (rsv_en && rsv_select == AW'(i))
                w_busy_next[i] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    assign busy = r_busy;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd_busy
        logic [AW-1:0] w_sel;
        assign w_sel = rd_select[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic w_hit;
        assign w_hit = (w_sel != '0) &&
                       ((wr_en[0] && w_ws0 == w_sel) || (wr_en[1] && w_ws1 == w_sel));
        assign rd_busy[k] = w_hit ? (rsv_en && rsv_select == w_sel) : r_busy[w_sel];
`else
        assign rd_busy[k] = r_busy[w_sel];
`endif
    end

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Register file with NREAD combinational read ports, two write
//               ports (port 1 wins on collision) and a busy-bit scoreboard.
//               Register 0 reads zero and ignores writes.
//   clock      sole clock, rising edge
//   reset_n    synchronous active-low reset
//   bus        register_file_mp_if slave modport (reads, writes,
//              reservation, busy flags, conflict pulse)
// Macros      : REGFILE_BYPASS_EN - reads of a register written this cycle
//               return the incoming write data (port 1 priority)
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NREAD = DEF_NREAD
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    register_file_mp_if.slave   bus
);

    localparam int AW = aw_of(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic             r_conflict;
    logic [AW-1:0]    w_ws0;
    logic [AW-1:0]    w_ws1;
    logic [XLEN-1:0]  w_wd0;
    logic [XLEN-1:0]  w_wd1;
    // Full busy vector is exported for debug; only the per-port view is used here.
    logic [NREGS-1:0] w_busy_vec_unused;

    assign w_ws0 = bus.wr_select[0  +: AW];
    assign w_ws1 = bus.wr_select[AW +: AW];
    assign w_wd0 = bus.wr_data[0    +: XLEN];
    assign w_wd1 = bus.wr_data[XLEN +: XLEN];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_conflict <= 1'b0;
        end else begin
            // Entry 0 is never written, so it holds its reset zero.
            for (int i = 1; i < NREGS; i++) begin
                if (bus.wr_en[1] && w_ws1 == AW'(i))
                    r_regs[i] <= w_wd1;
                else if (bus.wr_en[0] && w_ws0 == AW'(i))
                    r_regs[i] <= w_wd0;
            end
            r_conflict <= (&bus.wr_en) && (w_ws0 == w_ws1) && (w_ws0 != '0);
        end
    end

    assign bus.conflict = r_conflict;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   w_sel;
        logic [XLEN-1:0] w_val;
        assign w_sel = bus.rd_select[k*AW +: AW];
        always_comb begin
            w_val = r_regs[w_sel];
            if (w_sel == '0)
                w_val = '0;
`ifdef REGFILE_BYPASS_EN
            else if (bus.wr_en[1] && w_ws1 == w_sel)
                w_val = w_wd1;
            else if (bus.wr_en[0] && w_ws0 == w_sel)
                w_val = w_wd0;
`endif
        end
        assign bus.rd_data[k*XLEN +: XLEN] = w_val;
    end

    register_file_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .rsv_en     (bus.rsv_en),
        .rsv_select (bus.rsv_select),
        .wr_en      (bus.wr_en),
        .wr_select  (bus.wr_select),
        .rd_select  (bus.rd_select),
        .busy       (w_busy_vec_unused),
        .rd_busy    (bus.rd_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_mp
// Description : Directed self-checking bench for register_file_mp. Covers a
//               default instance (32x32, 2 read ports) and a 64-bit, 16-entry,
//               4-read-port instance. Expectations follow REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clock = ~clock;

    register_file_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_a ();
    register_file_mp_if #(.XLEN(64), .NREGS(16), .NREAD(4)) bus_b ();

    register_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    register_file_mp #(.XLEN(64), .NREGS(16), .NREAD(4)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_a();
        bus_a.wr_en = '0; bus_a.wr_select = '0; bus_a.wr_data = '0;
        bus_a.rsv_en = 1'b0; bus_a.rsv_select = '0; bus_a.rd_select = '0;
    endtask

    task automatic idle_b();
        bus_b.wr_en = '0; bus_b.wr_select = '0; bus_b.wr_data = '0;
        bus_b.rsv_en = 1'b0; bus_b.rsv_select = '0; bus_b.rd_select = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_a();
        idle_b();
        repeat (2) tick();
        reset_n = 1'b1;

        // Reset state
        bus_a.rd_select = {5'd5, 5'd5}; #1;
        chk("rst_data", bus_a.rd_data[31:0], 64'h0);
        chk("rst_busy", bus_a.rd_busy, 64'h0);
        chk("rst_conflict", bus_a.conflict, 64'h0);

        // Write r5 while reserving it, then reset with a discarded write/reserve
        bus_a.wr_en = 2'b01; bus_a.wr_select = {5'd0, 5'd5};
        bus_a.wr_data = {32'h0, 32'hDEADBEEF};
        bus_a.rsv_en = 1'b1; bus_a.rsv_select = 5'd5;
        tick(); idle_a(); bus_a.rd_select = {5'd5, 5'd5}; #1;
        chk("pre_rst_data", bus_a.rd_data[31:0], 64'hDEADBEEF);
        chk("pre_rst_busy", bus_a.rd_busy, 64'h3);
        reset_n = 1'b0;
        bus_a.wr_en = 2'b01; bus_a.wr_select = {5'd0, 5'd6};
        bus_a.wr_data = {32'h0, 32'h1}; bus_a.rsv_en = 1'b1; bus_a.rsv_select = 5'd6;
        tick(); reset_n = 1'b1; idle_a(); bus_a.rd_select = {5'd6, 5'd5}; #1;
        chk("rst_r5", bus_a.rd_data[31:0], 64'h0);
        chk("rst_r6_discard", bus_a.rd_data[63:32], 64'h0);
        chk("rst_busy_clr", bus_a.rd_busy, 64'h0);
        chk("rst_conflict2", bus_a.conflict, 64'h0);

        // Dual write to distinct registers
        bus_a.wr_en = 2'b11; bus_a.wr_select = {5'd7, 5'd3};
        bus_a.wr_data = {32'h22222222, 32'h11111111};
        bus_a.rd_select = {5'd7, 5'd3}; #1;
        chk("dual_same_p0", bus_a.rd_data[31:0], BYP ? 64'h11111111 : 64'h0);
        chk("dual_same_p1", bus_a.rd_data[63:32], BYP ? 64'h22222222 : 64'h0);
        tick(); idle_a(); bus_a.rd_select = {5'd7, 5'd3}; #1;
        chk("dual_r3", bus_a.rd_data[31:0], 64'h11111111);
        chk("dual_r7", bus_a.rd_data[63:32], 64'h22222222);
        chk("dual_conflict", bus_a.conflict, 64'h0);

        // Collision on r9: port 1 wins, one-cycle conflict pulse
        bus_a.wr_en = 2'b11; bus_a.wr_select = {5'd9, 5'd9};
        bus_a.wr_data = {32'h0000BBBB, 32'hAAAA0000};
        bus_a.rd_select = {5'd9, 5'd9}; #1;
        chk("coll_same", bus_a.rd_data[31:0], BYP ? 64'h0000BBBB : 64'h0);
        tick(); idle_a(); bus_a.rd_select = {5'd9, 5'd9}; #1;
        chk("coll_r9", bus_a.rd_data[31:0], 64'h0000BBBB);
        chk("coll_pulse", bus_a.conflict, 64'h1);
        tick(); #1;
        chk("coll_pulse_end", bus_a.conflict, 64'h0);

        // Collision on r0: no conflict, r0 stays zero
        bus_a.wr_en = 2'b11; bus_a.wr_select = {5'd0, 5'd0};
        bus_a.wr_data = {32'h12345678, 32'h9ABCDEF0};
        tick(); idle_a(); #1;
        chk("r0_coll_conflict", bus_a.conflict, 64'h0);
        chk("r0_read", bus_a.rd_data, 64'h0);

        // Scoreboard
        bus_a.rsv_en = 1'b1; bus_a.rsv_select = 5'd12;
        bus_a.rd_select = {5'd12, 5'd12}; #1;
        chk("rsv_same_cycle", bus_a.rd_busy, 64'h0);
        tick(); idle_a(); bus_a.rd_select = {5'd12, 5'd12}; #1;
        chk("rsv_busy", bus_a.rd_busy, 64'h3);
        bus_a.wr_en = 2'b01; bus_a.wr_select = {5'd0, 5'd12};
        bus_a.wr_data = {32'h0, 32'h5};
        bus_a.rsv_en = 1'b1; bus_a.rsv_select = 5'd12; #1;
        chk("rsv_wr_same", bus_a.rd_busy, 64'h3);
        tick(); idle_a(); bus_a.rd_select = {5'd12, 5'd12}; #1;
        chk("rsv_wr_busy", bus_a.rd_busy, 64'h3);
        chk("rsv_wr_data", bus_a.rd_data[63:32], 64'h5);
        bus_a.wr_en = 2'b10; bus_a.wr_select = {5'd12, 5'd0};
        bus_a.wr_data = {32'h7, 32'h0}; #1;
        chk("clr_same", bus_a.rd_busy, BYP ? 64'h0 : 64'h3);
        tick(); idle_a(); bus_a.rd_select = {5'd12, 5'd12}; #1;
        chk("clr_busy", bus_a.rd_busy, 64'h0);
        chk("clr_data", bus_a.rd_data[31:0], 64'h7);
        bus_a.rsv_en = 1'b1; bus_a.rsv_select = 5'd0;
        tick(); idle_a(); #1;
        chk("rsv_r0", bus_a.rd_busy, 64'h0);

        // Same-cycle read of a register being written
        bus_a.wr_en = 2'b01; bus_a.wr_select = {5'd0, 5'd4};
        bus_a.wr_data = {32'h0, 32'h00001234};
        tick(); idle_a();
        bus_a.wr_en = 2'b01; bus_a.wr_select = {5'd0, 5'd4};
        bus_a.wr_data = {32'h0, 32'hCAFEF00D};
        bus_a.rd_select = {5'd4, 5'd4}; #1;
        chk("byp_same", bus_a.rd_data[31:0], BYP ? 64'hCAFEF00D : 64'h00001234);
        tick(); idle_a(); bus_a.rd_select = {5'd4, 5'd4}; #1;
        chk("byp_next", bus_a.rd_data[31:0], 64'hCAFEF00D);

        // Wide instance: 64-bit, 16 entries, 4 read ports
        bus_b.wr_en = 2'b11; bus_b.wr_select = {4'd7, 4'd3};
        bus_b.wr_data = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        tick(); idle_b();
        bus_b.rd_select = {4'd7, 4'd3, 4'd7, 4'd3}; #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("sw_a_p%0d", k), bus_b.rd_data[k*64 +: 64],
                (k % 2 == 0) ? 64'h0123456789ABCDEF : 64'hFEDCBA9876543210);
        bus_b.rd_select = {4'd3, 4'd7, 4'd3, 4'd7}; #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("sw_b_p%0d", k), bus_b.rd_data[k*64 +: 64],
                (k % 2 == 0) ? 64'hFEDCBA9876543210 : 64'h0123456789ABCDEF);
        chk("sw_conflict", bus_b.conflict, 64'h0);

        bus_b.rsv_en = 1'b1; bus_b.rsv_select = 4'd12;
        tick(); idle_b(); bus_b.rd_select = {4{4'd12}}; #1;
        chk("sw_rsv_busy", bus_b.rd_busy, 64'hF);
        bus_b.wr_en = 2'b01; bus_b.wr_select = {4'd0, 4'd12};
        bus_b.wr_data = {64'h0, 64'h5};
        bus_b.rsv_en = 1'b1; bus_b.rsv_select = 4'd12;
        tick(); idle_b(); bus_b.rd_select = {4{4'd12}}; #1;
        chk("sw_rsv_wr_busy", bus_b.rd_busy, 64'hF);
        for (int k = 0; k < 4; k++)
            chk($sformatf("sw_r12_p%0d", k), bus_b.rd_data[k*64 +: 64], 64'h5);
        bus_b.wr_en = 2'b01; bus_b.wr_select = {4'd0, 4'd12};
        bus_b.wr_data = {64'h0, 64'h9};
        tick(); idle_b(); bus_b.rd_select = {4{4'd12}}; #1;
        chk("sw_clr_busy", bus_b.rd_busy, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
